// File: rtl/countdown_sequencer.sv
// countdown_sequencer
// Single-clock sequenced down-counter with load, run, pause and reload control.
// One-shot (mode=0) stops in DONE at terminal count; auto-reload (mode=1)
// reloads the last accepted start value and keeps running. Every terminal count
// raises a one-cycle done pulse and bumps a saturating period counter (laps).
// Per-cycle command priority is abort > start > pause > tick_en. Each state
// ignores any command that does not apply to it.
module countdown_sequencer #(
   parameter int WIDTH = 5,
   parameter int LAP_W = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             mode,
   input  logic             tick_en,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             busy,
   output logic             done,
   output logic [LAP_W-1:0] laps
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_done;
   logic [LAP_W-1:0] r_laps;

   // A zero start value finishes immediately; there is no period to count.
   wire             w_load_zero = (load_val == '0);
   // The count is at its last step, so the next tick is a terminal count.
   wire             w_last      = (r_count == WIDTH'(1));
   // The lap counter holds at all-ones and does not wrap.
   wire [LAP_W-1:0] w_laps_inc  = (&r_laps) ? r_laps : r_laps + LAP_W'(1);

   // Main sequencer: state, count, reload value, lap count and done pulse.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
         r_laps   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_reload <= load_val;
                  r_count  <= load_val;
                  r_laps   <= '0;
                  if (w_load_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (start) begin
                  // Restart with the new value; the period count starts over.
                  r_reload <= load_val;
                  r_count  <= load_val;
                  r_laps   <= '0;
                  if (w_load_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end else if (pause) begin
                  // A tick arriving with the pause is dropped.
                  r_state <= PAUSED;
               end else if (tick_en) begin
                  if (w_last) begin
                     r_done <= 1'b1;
                     r_laps <= w_laps_inc;
                     if (mode) begin
                        r_count <= r_reload;
                     end else begin
                        r_count <= '0;
                        r_state <= DONE;
                     end
                  end else if (r_count != '0) begin
                     r_count <= r_count - WIDTH'(1);
                  end
               end
            end
            PAUSED: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (start) begin
                  // Resume where the count was frozen; the reload value is kept.
                  r_state <= RUN;
               end
            end
            DONE: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (start) begin
                  r_reload <= load_val;
                  r_count  <= load_val;
                  r_laps   <= '0;
                  if (w_load_zero) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   assign count = r_count;
   assign state = r_state;
   assign busy  = (r_state == RUN) || (r_state == PAUSED);
   assign done  = r_done;
   assign laps  = r_laps;

endmodule
